// File: rtl/muldiv_16bit_pkg.sv
// Shared types and constants for the iterative 16-bit multiply/divide unit.
// Signed helpers are used only when MULDIV_SIGNED_OPS_EN is defined.
package muldiv_pkg;

    localparam int WIDTH = 16;
    localparam int ITER  = WIDTH;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam logic [15:0] DIV0_QUOTIENT = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic [15:0] neg16(input logic [15:0] v);
        neg16 = (~v) + 16'd1;
    endfunction

    function automatic logic [31:0] neg32(input logic [31:0] v);
        neg32 = (~v) + 32'd1;
    endfunction

    // -32768 maps to 0x8000, which the unsigned core reads as +32768
    function automatic logic [15:0] abs16(input logic [15:0] v);
        abs16 = v[15] ? neg16(v) : v;
    endfunction

endpackage

// File: rtl/muldiv_16bit_if.sv
// Request/result bundle between the control unit and the multiply/divide unit.
// op_signed exists only when MULDIV_SIGNED_OPS_EN is defined.
interface muldiv_16bit_if;
    logic        start;
    logic        op;
`ifdef MULDIV_SIGNED_OPS_EN
    logic        op_signed;
`endif
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result_lo;
    logic [15:0] result_hi;
    logic        div_by_zero;

    modport master (
        output start, op, a, b,
`ifdef MULDIV_SIGNED_OPS_EN
        output op_signed,
`endif
        input  busy, done, result_lo, result_hi, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
`ifdef MULDIV_SIGNED_OPS_EN
        input  op_signed,
`endif
        output busy, done, result_lo, result_hi, div_by_zero
    );
endinterface

// File: rtl/muldiv_16bit_step.sv
// One iteration of the shift-add multiplier / restoring divider.
// acc holds {upper, lower} for multiply and {remainder, quotient} for divide.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic [31:0] acc,
    input  logic [15:0] opnd,
    input  logic        op,
    output logic [31:0] acc_next
);

    logic [16:0] sum_s;
    logic [16:0] rem_s;

    // Next accumulator for the selected operation
    always_comb begin
        sum_s    = {1'b0, acc[31:16]} + {1'b0, opnd};
        rem_s    = acc[31:15];
        acc_next = 32'd0;
        case (op)
            OP_MUL: begin
                if (acc[0]) begin
                    acc_next = {sum_s, acc[15:1]};
                end else begin
                    acc_next = {1'b0, acc[31:1]};
                end
            end
            OP_DIV: begin
                // A successful trial subtract always leaves a remainder below the divisor
                if (rem_s >= {1'b0, opnd}) begin
                    acc_next = {rem_s[15:0] - opnd, acc[14:0], 1'b1};
                end else begin
                    acc_next = {rem_s[15:0], acc[14:0], 1'b0};
                end
            end
            default: acc_next = acc;
        endcase
    end

endmodule

// File: rtl/muldiv_16bit.sv
// Iterative 16-bit multiply/divide unit: 17-cycle start-to-done, 1 cycle for divide-by-zero.
// Define MULDIV_SIGNED_OPS_EN to add op_signed (two's-complement operands, sign fix-up on DONE).
module muldiv_16bit
    import muldiv_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    muldiv_16bit_if.slave bus
);

    state_e      state_r;
    logic [3:0]  cnt_r;
    logic [31:0] acc_r;
    logic [15:0] opnd_r;
    logic        op_r;
    logic        busy_r;
    logic        done_r;
    logic        dbz_r;
    logic [15:0] lo_r;
    logic [15:0] hi_r;

    logic [31:0] step_next_s;
    logic [15:0] a_eff_s;
    logic [15:0] b_eff_s;
    logic [15:0] fin_lo_s;
    logic [15:0] fin_hi_s;
`ifdef MULDIV_SIGNED_OPS_EN
    logic        neg_lo_r;
    logic        neg_hi_r;
    logic        neg_lo_s;
    logic        neg_hi_s;
`endif

    muldiv_step u_step (
        .acc      (acc_r),
        .opnd     (opnd_r),
        .op       (op_r),
        .acc_next (step_next_s)
    );

    // Operand magnitudes and result signs captured at start
    always_comb begin
        a_eff_s = bus.a;
        b_eff_s = bus.b;
`ifdef MULDIV_SIGNED_OPS_EN
        if (bus.op_signed) begin
            a_eff_s  = abs16(bus.a);
            b_eff_s  = abs16(bus.b);
            neg_lo_s = bus.a[15] ^ bus.b[15];
            neg_hi_s = (bus.op == OP_MUL) ? (bus.a[15] ^ bus.b[15]) : bus.a[15];
        end else begin
            neg_lo_s = 1'b0;
            neg_hi_s = 1'b0;
        end
`endif
    end

    // Final result from the last iteration, with sign restored when needed
    always_comb begin
        fin_lo_s = step_next_s[15:0];
        fin_hi_s = step_next_s[31:16];
`ifdef MULDIV_SIGNED_OPS_EN
        if (op_r == OP_MUL) begin
            if (neg_lo_r) begin
                {fin_hi_s, fin_lo_s} = neg32(step_next_s);
            end else begin
                {fin_hi_s, fin_lo_s} = step_next_s;
            end
        end else begin
            fin_lo_s = neg_lo_r ? neg16(step_next_s[15:0])  : step_next_s[15:0];
            fin_hi_s = neg_hi_r ? neg16(step_next_s[31:16]) : step_next_s[31:16];
        end
`endif
    end

    // Control FSM, iteration state and registered handshake/results
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= S_IDLE;
            cnt_r    <= 4'd0;
            acc_r    <= 32'd0;
            opnd_r   <= 16'd0;
            op_r     <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dbz_r    <= 1'b0;
            lo_r     <= 16'd0;
            hi_r     <= 16'd0;
`ifdef MULDIV_SIGNED_OPS_EN
            neg_lo_r <= 1'b0;
            neg_hi_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        op_r   <= bus.op;
                        cnt_r  <= 4'd0;
                        busy_r <= 1'b1;
                        opnd_r <= (bus.op == OP_MUL) ? a_eff_s : b_eff_s;
                        acc_r  <= {16'd0, (bus.op == OP_MUL) ? b_eff_s : a_eff_s};
`ifdef MULDIV_SIGNED_OPS_EN
                        neg_lo_r <= neg_lo_s;
                        neg_hi_r <= neg_hi_s;
`endif
                        if ((bus.op == OP_DIV) && (bus.b == 16'd0)) begin
                            state_r <= S_DONE;
                            done_r  <= 1'b1;
                            dbz_r   <= 1'b1;
                            lo_r    <= DIV0_QUOTIENT;
                            hi_r    <= bus.a;
                        end else begin
                            state_r <= S_RUN;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                S_RUN: begin
                    acc_r <= step_next_s;
                    cnt_r <= cnt_r + 4'd1;
                    if (cnt_r == 4'(ITER - 1)) begin
                        state_r <= S_DONE;
                        done_r  <= 1'b1;
                        dbz_r   <= 1'b0;
                        lo_r    <= fin_lo_s;
                        hi_r    <= fin_hi_s;
                    end else begin
                        state_r <= S_RUN;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= S_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.result_lo   = lo_r;
    assign bus.result_hi   = hi_r;

endmodule

// File: tb/tb_muldiv_16bit.sv
// Bench for muldiv_16bit: directed cases with literal expectations plus random traffic
// checked every cycle against an arithmetic/latency model.
module tb_muldiv_16bit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    muldiv_16bit_if bus ();

    muldiv_16bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {div_by_zero, hi, lo} straight from the arithmetic definition
    function automatic logic [32:0] model_calc(input logic op, input logic sgn,
                                               input logic [15:0] a, input logic [15:0] b);
        int sa, sb, p, q, r;
        logic [31:0] up;
        if (op && b == 16'd0) return {1'b1, a, 16'hFFFF};
        if (sgn) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            if (!op) begin
                p = sa * sb;
                return {1'b0, 32'(p)};
            end
            q = sa / sb;
            r = sa % sb;
            return {1'b0, 16'(r), 16'(q)};
        end
        if (!op) begin
            up = 32'(a) * 32'(b);
            return {1'b0, up};
        end
        return {1'b0, a % b, a / b};
    endfunction

    logic        sgn_in;
`ifdef MULDIV_SIGNED_OPS_EN
    assign sgn_in = bus.op_signed;
`else
    assign sgn_in = 1'b0;
`endif

    // Reference model: an accepted request keeps the unit busy 17 cycles (1 for x/0)
    int          m_left = 0;
    logic [32:0] m_pend = 33'd0;
    logic        m_ok = 1'b0;
    logic        m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
    logic [15:0] m_lo = 16'd0, m_hi = 16'd0;

    always @(posedge clk) begin : model
        int          left_n;
        logic [32:0] r;
        if (rst) begin
            m_ok   <= 1'b1;
            m_left <= 0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            m_lo   <= 16'd0;
            m_hi   <= 16'd0;
        end else begin
            left_n = m_left;
            r      = m_pend;
            if (left_n > 0) begin
                left_n = left_n - 1;
            end else if (bus.start) begin
                r      = model_calc(bus.op, sgn_in, bus.a, bus.b);
                left_n = (bus.op && bus.b == 16'd0) ? 1 : 17;
            end
            m_pend <= r;
            m_left <= left_n;
            m_busy <= (left_n > 0);
            m_done <= (left_n == 1);
            if (left_n == 1) {m_dbz, m_hi, m_lo} <= r;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            check("busy", 32'(bus.busy), 32'(m_busy));
            check("done", 32'(bus.done), 32'(m_done));
            check("div_by_zero", 32'(bus.div_by_zero), 32'(m_dbz));
            check("result_lo", 32'(bus.result_lo), 32'(m_lo));
            check("result_hi", 32'(bus.result_hi), 32'(m_hi));
        end
    end

    task automatic drive(input logic st, input logic op, input logic sg,
                         input logic [15:0] a, input logic [15:0] b);
        bus.start = st;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
`ifdef MULDIV_SIGNED_OPS_EN
        bus.op_signed = sg;
`else
        if (sg) $display("signed request ignored in unsigned build");
`endif
    endtask

    // Wait for done, counting cycles from the start edge; busy must stay high until then
    task automatic wait_done(input int first_k, output int lat);
        lat = -1;
        for (int k = first_k; k <= 40; k++) begin
            @(negedge clk);
            check("busy_during_op", 32'(bus.busy), 32'd1);
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input logic op, input logic sg, input logic [15:0] a,
                          input logic [15:0] b, output int lat);
        @(posedge clk);
        #1 drive(1'b1, op, sg, a, b);
        @(posedge clk);
        #1 drive(1'b0, ~op, 1'b0, 16'($urandom), 16'($urandom));
        wait_done(1, lat);
    endtask

    initial begin : stim
        int lat;
        int pulses;
        drive(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_res", {bus.result_hi, bus.result_lo}, 32'd0);
        check("reset_dbz", 32'(bus.div_by_zero), 32'd0);

        run_op(1'b0, 1'b0, 16'hFFFF, 16'hFFFF, lat);
        check("mul_ffff_lat", 32'(lat), 32'd17);
        check("mul_ffff_res", {bus.result_hi, bus.result_lo}, 32'hFFFE_0001);
        @(negedge clk);
        check("mul_busy_after", 32'(bus.busy), 32'd0);

        run_op(1'b1, 1'b0, 16'd1000, 16'd7, lat);
        check("div_1000_7_lat", 32'(lat), 32'd17);
        check("div_1000_7_res", {bus.result_hi, bus.result_lo}, 32'h0006_008E);
        check("div_1000_7_dbz", 32'(bus.div_by_zero), 32'd0);

        run_op(1'b1, 1'b0, 16'h1234, 16'h0000, lat);
        check("div0_lat", 32'(lat), 32'd1);
        check("div0_res", {bus.result_hi, bus.result_lo}, 32'h1234_FFFF);
        check("div0_dbz", 32'(bus.div_by_zero), 32'd1);
        @(negedge clk);
        check("div0_busy_after", 32'(bus.busy), 32'd0);
        check("div0_hold", {bus.result_hi, bus.result_lo}, 32'h1234_FFFF);

        // Start while busy is ignored
        @(posedge clk);
        #1 drive(1'b1, 1'b0, 1'b0, 16'd3, 16'd5);
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        repeat (4) @(posedge clk);
        #1 drive(1'b1, 1'b0, 1'b0, 16'd9, 16'd9);
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        wait_done(6, lat);
        check("busy_start_lat", 32'(lat), 32'd17);
        check("busy_start_res", {bus.result_hi, bus.result_lo}, 32'h0000_000F);

        // Back-to-back issue at T+18
        run_op(1'b0, 1'b0, 16'h1234, 16'h0010, lat);
        check("b2b_lat", 32'(lat), 32'd17);
        check("b2b_res", {bus.result_hi, bus.result_lo}, 32'h0001_2340);

        // Reset in the middle of an operation
        @(posedge clk);
        #1 drive(1'b1, 1'b0, 1'b0, 16'h00FF, 16'h0101);
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
        check("rst_mid_res", {bus.result_hi, bus.result_lo}, 32'd0);
        pulses = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check("rst_mid_no_done", 32'(pulses), 32'd0);
        run_op(1'b1, 1'b0, 16'hFFFF, 16'h0010, lat);
        check("after_rst_lat", 32'(lat), 32'd17);
        check("after_rst_res", {bus.result_hi, bus.result_lo}, 32'h000F_0FFF);

`ifdef MULDIV_SIGNED_OPS_EN
        run_op(1'b1, 1'b1, 16'hFFF9, 16'd2, lat);
        check("sdiv_m7_2", {bus.result_hi, bus.result_lo}, 32'hFFFF_FFFD);
        run_op(1'b0, 1'b1, 16'hFFFD, 16'd4, lat);
        check("smul_m3_4", {bus.result_hi, bus.result_lo}, 32'hFFFF_FFF4);
        run_op(1'b1, 1'b1, 16'h8000, 16'hFFFF, lat);
        check("sdiv_min_m1", {bus.result_hi, bus.result_lo}, 32'h0000_8000);
        check("sdiv_min_lat", 32'(lat), 32'd17);
`endif

        // Random traffic, including requests while busy and divides by zero
        for (int i = 0; i < 1500; i++) begin
            logic [15:0] ra, rb;
            @(posedge clk);
            ra = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 16'h0000 :
                 ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            #1 drive(1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), ra, rb);
        end
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        repeat (40) @(posedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
